// File: rtl/trng_collector.sv
// -----------------------------------------------------------------------------
// trng_collector
//
// Consumer end of a ring-oscillator TRNG bitstream. The asynchronous raw bit
// is synchronised, sampled once every SAMPLE_DIV clocks, debiased with a von
// Neumann corrector and packed MSB-first into WIDTH-bit words. Every raw
// sample feeds a repetition-count health test. A stuck source latches a sticky
// failure that only reset clears.
//
// Ports
//   clk_in    system clock
//   rst_      asynchronous active-low reset
//   en        collection enable (ignored once failed)
//   prn_in    raw random bit, asynchronous to clk_in
//   data_out  last completed word (changes only when a word completes)
//   valid     data_out holds a word not yet taken by the consumer
//   ready     consumer takes the word when valid && ready
//   fail      sticky repetition-test failure
// -----------------------------------------------------------------------------
module trng_collector #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_DIV  = 16,
   parameter int REP_LIMIT   = 32
) (
   input  logic             clk_in,
   input  logic             rst_,
   input  logic             en,
   input  logic             prn_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             fail
);

   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRST,
      ST_SECOND,
      ST_FULL,
      ST_FAIL
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   a_q, a_d;
   logic [WIDTH-1:0]       word_q, word_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   prev_q, prev_d;
   logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;

   logic                   s_bit;
   logic                   sampling;
   logic                   sample;
   logic [REP_W-1:0]       rep_new;
   logic [WIDTH-1:0]       word_shift;

   assign s_bit      = sync_q[SYNC_STAGES-1];
   assign sampling   = (state_q == ST_FIRST) || (state_q == ST_SECOND);
   assign sample     = sampling && (cnt_q == CNT_LAST);
   assign word_shift = {word_q[WIDTH-2:0], a_q};

   // rep_cnt_q == 0 marks "no raw sample yet since enable", so the first
   // sample always starts a fresh run of length 1.
   assign rep_new = ((rep_cnt_q == '0) || (s_bit != prev_q)) ? REP_ONE :
                    (rep_cnt_q == REP_MAX)                   ? REP_MAX :
                                                               rep_cnt_q + 1'b1;

   assign data_out = data_q;
   assign valid    = (state_q == ST_FULL);
   assign fail     = (state_q == ST_FAIL);

   // NOTE: every register, including the synchroniser, is cleared by the async
   // reset and updated with non-blocking assignments so all flops see the same
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_) begin
      if (!rst_) begin
         state_q   <= ST_IDLE;
         sync_q    <= '0;
         cnt_q     <= '0;
         a_q       <= 1'b0;
         word_q    <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         prev_q    <= 1'b0;
         rep_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], prn_in};
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         word_q    <= word_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         prev_q    <= prev_d;
         rep_cnt_q <= rep_cnt_d;
      end
   end

   // NOTE: every output of this block gets a default before any branch, so no
   // path can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      a_d       = a_q;
      word_d    = word_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      prev_d    = prev_q;
      rep_cnt_d = rep_cnt_q;

      // Sample timer only runs while collecting a pair; it idles at zero in
      // IDLE, FULL and FAIL so the next sample is a full period away.
      if (sampling) begin
         cnt_d = sample ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_FIRST;
         end
         ST_FIRST: begin
            if (sample) begin
               a_d     = s_bit;
               state_d = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (sample) begin
               state_d = ST_FIRST;
               if (a_q != s_bit) begin
                  if (bit_cnt_q == BIT_LAST) begin
                     data_d    = word_shift;
                     word_d    = '0;
                     bit_cnt_d = '0;
                     state_d   = ST_FULL;
                  end else begin
                     word_d    = word_shift;
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end
         ST_FULL: begin
            if (ready) state_d = ST_FIRST;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: state_d = ST_IDLE;
      endcase

      // Health test sees every raw sample, both members of a pair.
      if (sample) begin
         prev_d    = s_bit;
         rep_cnt_d = rep_new;
         // A tripped test wins over a word completing on the same sample:
         // the word is dropped and data_out keeps its previous contents.
         if (rep_new == REP_MAX) begin
            state_d   = ST_FAIL;
            word_d    = '0;
            bit_cnt_d = '0;
            data_d    = data_q;
         end
      end

      // Disable abandons everything in flight except the last delivered word.
      if (!en && (state_q != ST_FAIL)) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         a_d       = 1'b0;
         word_d    = '0;
         bit_cnt_d = '0;
         data_d    = data_q;
         prev_d    = 1'b0;
         rep_cnt_d = '0;
      end
   end

endmodule
